// File: rtl/conv_ctrl_pkg.sv
// Shared control definitions for the CONV sub-top: FSM state encoding,
// counter widths and layer-shape helpers (also used by the address generator).
package conv_ctrl_pkg;

  localparam int COL_W  = 16;
  localparam int ROW_W  = 16;
  localparam int TILE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    MAC,
    FLUSH,
    DONE
  } conv_state_t;

  // Number of 32-bit MAC steps per window: each word carries 4 int8 channels.
  function automatic int calc_mac_len(input int kernel_w, input int ifm_c);
    return kernel_w * kernel_w * ifm_c / 4;
  endfunction

  function automatic int calc_num_tiles(input int ofm_c, input int pe_num);
    return ofm_c / pe_num;
  endfunction

endpackage

// File: rtl/conv_pixel_counter.sv
// Nested col/row/tile counter for output-pixel order (column fastest).
// Holds at the final pixel of the layer; last flags that position.
module conv_pixel_counter
  import conv_ctrl_pkg::*;
#(
  parameter int OFM_W     = 54,
  parameter int OFM_H     = 54,
  parameter int NUM_TILES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [TILE_W-1:0] tile,
  output logic              last
);

  logic col_last;
  logic row_last;
  logic tile_last;

  assign col_last  = (col  == COL_W'(OFM_W - 1));
  assign row_last  = (row  == ROW_W'(OFM_H - 1));
  assign tile_last = (tile == TILE_W'(NUM_TILES - 1));
  assign last      = col_last && row_last && tile_last;

  // Advancing past the final pixel is suppressed so counters never overrun.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      tile <= '0;
    end else if (advance && !last) begin
      if (col_last) begin
        col <= '0;
        if (row_last) begin
          row  <= '0;
          tile <= tile + TILE_W'(1);
        end else begin
          row <= row + ROW_W'(1);
        end
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Layer-level control FSM for the PE cluster: primes the BRAM read path,
// runs MAC_LEN MAC steps per window and qualifies each OFM word with one valid.
module conv_window_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int KERNEL_W = 3,
  parameter int IFM_C    = 16,
  parameter int OFM_W    = 54,
  parameter int OFM_H    = 54,
  parameter int OFM_C    = 32,
  parameter int PE_NUM   = 16,
  parameter int BRAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              cal_start,
  output logic [PE_NUM-1:0] PE_reset,
  output logic [PE_NUM-1:0] PE_finish,
  output logic [PE_NUM-1:0] valid,
  output logic [COL_W-1:0]  ofm_col,
  output logic [ROW_W-1:0]  ofm_row,
  output logic [TILE_W-1:0] ofm_tile,
  output logic              busy,
  output logic              done
);

  localparam int MAC_LEN   = calc_mac_len(KERNEL_W, IFM_C);
  localparam int NUM_TILES = calc_num_tiles(OFM_C, PE_NUM);
  localparam int MAC_W     = $clog2(MAC_LEN + 1);
  localparam int LAT_W     = 2;

  conv_state_t      state;
  conv_state_t      state_nxt;
  logic [MAC_W-1:0] mac_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             mac_last;
  logic             lat_last;
  logic             pix_last;
  logic             pix_advance;
  logic             pix_clear;

  assign mac_last = (mac_cnt == MAC_W'(MAC_LEN - 1));
  assign lat_last = (lat_cnt == LAT_W'(BRAM_LAT - 1));

  conv_pixel_counter #(
    .OFM_W     (OFM_W),
    .OFM_H     (OFM_H),
    .NUM_TILES (NUM_TILES)
  ) u_pixel_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (pix_clear),
    .advance (pix_advance),
    .col     (ofm_col),
    .row     (ofm_row),
    .tile    (ofm_tile),
    .last    (pix_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Both counters are zero whenever a PRIME or MAC phase is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      mac_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        PRIME: begin
          mac_cnt <= '0;
          lat_cnt <= lat_last ? '0 : lat_cnt + LAT_W'(1);
        end
        MAC: begin
          if (!stall) mac_cnt <= mac_last ? '0 : mac_cnt + MAC_W'(1);
        end
        default: begin
          mac_cnt <= '0;
          lat_cnt <= '0;
        end
      endcase
    end
  end

  // Strobes decode the registered state; only stall gates the MAC-phase ones.
  always_comb begin
    state_nxt   = state;
    pix_advance = 1'b0;
    pix_clear   = 1'b0;
    cal_start   = 1'b0;
    PE_reset    = '0;
    PE_finish   = '0;
    valid       = '0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = PRIME;
          pix_clear = 1'b1;
        end
      end
      PRIME: begin
        cal_start = 1'b1;
        PE_reset  = '1;
        if (lat_last) state_nxt = MAC;
      end
      MAC: begin
        if (!stall) begin
          cal_start = 1'b1;
          if (mac_last) begin
            PE_finish = '1;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        valid = '1;
        if (pix_last) begin
          state_nxt = DONE;
        end else begin
          state_nxt   = PRIME;
          pix_advance = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
        pix_clear = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
